// File: rtl/tick_debounce_pkg.sv
// Shared types and helpers for the tick/debounce controller.
// Repeat timing constants are only consumed when AUTOREPEAT_EN is defined.
package tick_debounce_pkg;

   // Per-button debounce state
   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_e;

   // Autorepeat: first repeat after REPEAT_DELAY slow ticks, then every REPEAT_RATE
   localparam int unsigned REPEAT_DELAY = 8;
   localparam int unsigned REPEAT_RATE  = 2;

   // Bits needed to hold the value max_val (minimum 1)
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((max_val >> i) != 0) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// Single-button debounce FSM with press/release pulses and a registered level.
// With AUTOREPEAT_EN defined, a held button also emits repeat press pulses.
module btn_debounce_fsm
   import tick_debounce_pkg::*;
#(
   parameter int unsigned DEB_TICKS = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic sample,
`ifdef AUTOREPEAT_EN
   input  logic tick_slow,
`endif
   output logic level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int unsigned CNT_W = cnt_width(DEB_TICKS);

   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             entering_pressed;

`ifdef AUTOREPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned REP_W   = cnt_width(REP_MAX);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [REP_W-1:0] rep_inc;
   logic [REP_W-1:0] rep_target;
   logic             rep_armed_q, rep_armed_d;
   logic             rep_fire;
`endif

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
`ifdef AUTOREPEAT_EN
         rep_cnt_q   <= '0;
         rep_armed_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
`ifdef AUTOREPEAT_EN
         rep_cnt_q   <= rep_cnt_d;
         rep_armed_q <= rep_armed_d;
`endif
      end
   end

   // Next state and next outputs; state only moves on fast ticks
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cnt_inc   = cnt_q + CNT_W'(1);
      level_d   = 1'b0;
      press_d   = 1'b0;
      release_d = 1'b0;

      if (tick) begin
         case (state_q)
            RELEASED: begin
               if (sample) begin
                  state_d = PRESS_WAIT;
                  cnt_d   = CNT_W'(1);
               end
            end
            PRESS_WAIT: begin
               if (!sample) begin
                  state_d = RELEASED;
                  cnt_d   = '0;
               end else if (cnt_inc == CNT_W'(DEB_TICKS)) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            PRESSED: begin
               if (!sample) begin
                  state_d = RELEASE_WAIT;
                  cnt_d   = CNT_W'(1);
               end
            end
            RELEASE_WAIT: begin
               if (sample) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else if (cnt_inc == CNT_W'(DEB_TICKS)) begin
                  state_d = RELEASED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = RELEASED;
               cnt_d   = '0;
            end
         endcase
      end

      entering_pressed = (state_q == PRESS_WAIT) && (state_d == PRESSED);
      level_d          = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      release_d        = (state_q == RELEASE_WAIT) && (state_d == RELEASED);
      press_d          = entering_pressed;

`ifdef AUTOREPEAT_EN
      // Slow ticks count only while the button stays solidly pressed
      rep_cnt_d   = rep_cnt_q;
      rep_armed_d = rep_armed_q;
      rep_inc     = rep_cnt_q + REP_W'(1);
      rep_target  = rep_armed_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);
      rep_fire    = 1'b0;
      if (entering_pressed) begin
         rep_cnt_d   = '0;
         rep_armed_d = 1'b0;
      end else if (tick_slow && (state_q == PRESSED) && (state_d == PRESSED)) begin
         if (rep_inc == rep_target) begin
            rep_fire    = 1'b1;
            rep_cnt_d   = '0;
            rep_armed_d = 1'b1;
         end else begin
            rep_cnt_d = rep_inc;
         end
      end
      press_d = entering_pressed || rep_fire;
`endif
   end

   assign level         = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

endmodule

// File: rtl/tick_debounce_ctrl.sv
// Fast/slow tick generation, 2-flop button synchronizers and a debounce FSM per button.
// Define AUTOREPEAT_EN to enable held-button repeat presses.
module tick_debounce_ctrl
   import tick_debounce_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned TICK_HZ   = 1200,
   parameter int unsigned SLOW_DIV  = 80,
   parameter int unsigned N_BTN     = 4,
   parameter int unsigned DEB_TICKS = 4
) (
   input  logic             CLKnexys,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   output logic             tick_1200,
   output logic             tick_15,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
   localparam int unsigned DIV_W  = cnt_width(DIV - 1);
   localparam int unsigned SLOW_W = cnt_width(SLOW_DIV - 1);

   logic [DIV_W-1:0]  fast_cnt_q, fast_cnt_d;
   logic [SLOW_W-1:0] slow_cnt_q, slow_cnt_d;
   logic              tick_q, tick_d;
   logic              tick15_q, tick15_d;
   logic [N_BTN-1:0]  sync1_q, sync1_d;
   logic [N_BTN-1:0]  sync2_q, sync2_d;

   // Counter, tick and synchronizer registers
   always_ff @(posedge CLKnexys) begin
      if (reset) begin
         fast_cnt_q <= '0;
         slow_cnt_q <= '0;
         tick_q     <= 1'b0;
         tick15_q   <= 1'b0;
         sync1_q    <= '0;
         sync2_q    <= '0;
      end else begin
         fast_cnt_q <= fast_cnt_d;
         slow_cnt_q <= slow_cnt_d;
         tick_q     <= tick_d;
         tick15_q   <= tick15_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
      end
   end

   // Ticks are decoded from the next counter values so they land in the DIV-1 cycle
   always_comb begin
      fast_cnt_d = fast_cnt_q + DIV_W'(1);
      if (fast_cnt_q == DIV_W'(DIV - 1)) begin
         fast_cnt_d = '0;
      end
      tick_d = (fast_cnt_d == DIV_W'(DIV - 1));

      slow_cnt_d = slow_cnt_q;
      if (tick_q) begin
         if (slow_cnt_q == SLOW_W'(SLOW_DIV - 1)) begin
            slow_cnt_d = '0;
         end else begin
            slow_cnt_d = slow_cnt_q + SLOW_W'(1);
         end
      end
      tick15_d = tick_d && (slow_cnt_d == SLOW_W'(SLOW_DIV - 1));

      sync1_d = btn_in;
      sync2_d = sync1_q;
   end

   assign tick_1200 = tick_q;
   assign tick_15   = tick15_q;

   // One independent debounce FSM per button, fed only from the synchronizer
   for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
      btn_debounce_fsm #(
         .DEB_TICKS (DEB_TICKS)
      ) u_fsm (
         .clk           (CLKnexys),
         .reset         (reset),
         .tick          (tick_q),
         .sample        (sync2_q[i]),
`ifdef AUTOREPEAT_EN
         .tick_slow     (tick15_q),
`endif
         .level         (btn_level[i]),
         .press_pulse   (btn_press[i]),
         .release_pulse (btn_release[i])
      );
   end

endmodule

// File: tb/tb_tick_debounce_ctrl.sv
// Self-checking bench for tick_debounce_ctrl: directed scenarios plus randomized
// button traffic against a run-length debounce model. Honors AUTOREPEAT_EN.
module tb_tick_debounce_ctrl;

   localparam int unsigned CLK_HZ    = 12000;
   localparam int unsigned TICK_HZ   = 1200;
   localparam int unsigned SLOW_DIV  = 4;
   localparam int unsigned N_BTN     = 4;
   localparam int unsigned DEB_TICKS = 3;
   localparam int unsigned DIV       = CLK_HZ / TICK_HZ;
   localparam int unsigned VW        = 3 * N_BTN + 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [N_BTN-1:0] btn_in;
   logic             tick_1200, tick_15;
   logic [N_BTN-1:0] btn_level, btn_press, btn_release;

   tick_debounce_ctrl #(
      .CLK_HZ    (CLK_HZ),
      .TICK_HZ   (TICK_HZ),
      .SLOW_DIV  (SLOW_DIV),
      .N_BTN     (N_BTN),
      .DEB_TICKS (DEB_TICKS)
   ) dut (
      .CLKnexys    (clk),
      .reset       (reset),
      .btn_in      (btn_in),
      .tick_1200   (tick_1200),
      .tick_15     (tick_15),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   always #5 clk = ~clk;

   int checks;
   int failures;

   // Reference model: cycle index since reset, input history, and per-button
   // debounced level with the length of the current run of disagreeing samples.
   int unsigned      mc;
   logic [N_BTN-1:0] hist[$];
   bit               m_lvl  [N_BTN];
   int               m_run  [N_BTN];
   int               m_held [N_BTN];
   logic             exp_tick, exp_t15;
   logic [N_BTN-1:0] exp_level, exp_press, exp_rel;

   logic [VW-1:0] obs_vec, exp_vec;
   assign obs_vec = {tick_1200, tick_15, btn_level, btn_press, btn_release};
   assign exp_vec = {exp_tick, exp_t15, exp_level, exp_press, exp_rel};

   task automatic model_reset();
      mc = 0;
      hist.delete();
      for (int i = 0; i < int'(N_BTN); i++) begin
         m_lvl[i]  = 1'b0;
         m_run[i]  = 0;
         m_held[i] = 0;
      end
      exp_tick  = 1'b0;
      exp_t15   = 1'b0;
      exp_level = '0;
      exp_press = '0;
      exp_rel   = '0;
   endtask

   // Advance the model by the current cycle, given the input driven in it
   task automatic model_advance(input logic [N_BTN-1:0] b);
      logic [N_BTN-1:0] s;
      bit               tk, t15;
      hist.push_back(b);
      s   = (mc >= 2) ? hist[mc - 2] : '0;
      tk  = ((mc % DIV) == DIV - 1);
      t15 = tk && (((mc / DIV) % SLOW_DIV) == SLOW_DIV - 1);
      exp_press = '0;
      exp_rel   = '0;
      if (tk) begin
         for (int i = 0; i < int'(N_BTN); i++) begin
`ifdef AUTOREPEAT_EN
            if (t15 && m_lvl[i] && m_run[i] == 0 && s[i]) begin
               m_held[i]++;
               if (m_held[i] == 8 || (m_held[i] > 8 && ((m_held[i] - 8) % 2) == 0))
                  exp_press[i] = 1'b1;
            end
`endif
            if (s[i] != m_lvl[i]) begin
               m_run[i]++;
               if (m_run[i] == int'(DEB_TICKS)) begin
                  m_lvl[i] = !m_lvl[i];
                  m_run[i] = 0;
                  if (m_lvl[i]) begin
                     exp_press[i] = 1'b1;
                     m_held[i]    = 0;
                  end else begin
                     exp_rel[i] = 1'b1;
                  end
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end
      mc++;
      exp_tick = ((mc % DIV) == DIV - 1);
      exp_t15  = exp_tick && (((mc / DIV) % SLOW_DIV) == SLOW_DIV - 1);
      for (int i = 0; i < int'(N_BTN); i++) exp_level[i] = m_lvl[i];
   endtask

   // Drive one cycle of inputs, step the model, and land 1 time unit after the edge
   task automatic run_cycle(input logic [N_BTN-1:0] b, input logic rst);
      btn_in = b;
      reset  = rst;
      if (rst) model_reset();
      else     model_advance(b);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      run_cycle(N_BTN'($urandom), 1'b1);
      if (obs_vec !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%b want=0", obs_vec);
      end
      checks++;
      run_cycle(4'b1111, 1'b0);
      if (obs_vec !== exp_vec) begin
         failures++;
         $display("FAIL reset_next mc=%0d got=%b want=%b", mc, obs_vec, exp_vec);
      end
      checks++;
   endtask

   task automatic test_tick_gen();
      int n_tick = 0;
      int n_t15  = 0;
      run_cycle('0, 1'b1);
      for (int c = 0; c < 100; c++) begin
         if (tick_1200 !== ((c % 10) == 9) || tick_15 !== (c == 39 || c == 79)) begin
            failures++;
            $display("FAIL tick_pattern cycle=%0d got tick=%b t15=%b", c, tick_1200, tick_15);
         end
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL tick_model mc=%0d got=%b want=%b", mc, obs_vec, exp_vec);
         end
         checks++;
         if (tick_1200 === 1'b1) n_tick++;
         if (tick_15 === 1'b1) n_t15++;
         run_cycle('0, 1'b0);
      end
      if (n_tick != 10 || n_t15 != 2) begin
         failures++;
         $display("FAIL tick_counts got ticks=%0d t15=%0d want 10 2", n_tick, n_t15);
      end
      checks++;
   endtask

   task automatic test_single_press();
      int n_press = 0;
      int p_cyc   = -1;
      run_cycle('0, 1'b1);
      for (int k = 0; k < 60; k++) begin
         run_cycle(4'b0001, 1'b0);
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL single_press mc=%0d got=%b want=%b", mc, obs_vec, exp_vec);
         end
         checks++;
         if (btn_press[0] === 1'b1) begin
            n_press++;
            p_cyc = int'(mc);
            if (btn_level[0] !== 1'b1) begin
               failures++;
               $display("FAIL press_level got=%b want=1", btn_level[0]);
            end
            checks++;
         end
      end
      if (n_press != 1 || p_cyc != 30) begin
         failures++;
         $display("FAIL press_timing got count=%0d cycle=%0d want 1 at 30", n_press, p_cyc);
      end
      checks++;
   endtask

   task automatic test_glitch();
      int n_evt = 0;
      int n_lvl = 0;
      run_cycle('0, 1'b1);
      for (int k = 0; k < 80; k++) begin
         run_cycle((k >= 5 && k < 20) ? 4'b0010 : 4'b0000, 1'b0);
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL glitch mc=%0d got=%b want=%b", mc, obs_vec, exp_vec);
         end
         checks++;
         if (btn_press[1] === 1'b1 || btn_release[1] === 1'b1) n_evt++;
         if (btn_level[1] !== 1'b0) n_lvl++;
      end
      if (n_evt != 0 || n_lvl != 0) begin
         failures++;
         $display("FAIL glitch_filter got pulses=%0d level_cycles=%0d want 0 0", n_evt, n_lvl);
      end
      checks++;
   endtask

   task automatic test_bounce_release();
      int n_rel2 = 0;
      int n_rel3 = 0;
      int r_cyc  = -1;
      logic [N_BTN-1:0] b;
      run_cycle('0, 1'b1);
      for (int k = 0; k < 130; k++) begin
         b = (k < 50) ? 4'b1100 : (k < 70) ? 4'b0000 : (k < 80) ? 4'b1100 : 4'b0000;
         run_cycle(b, 1'b0);
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL bounce mc=%0d got=%b want=%b", mc, obs_vec, exp_vec);
         end
         checks++;
         if (mc == 100) begin
            if (btn_level[3:2] !== 2'b11) begin
               failures++;
               $display("FAIL bounce_restart got level=%b want=11", btn_level[3:2]);
            end
            checks++;
         end
         if (btn_release[2] === 1'b1) n_rel2++;
         if (btn_release[3] === 1'b1) begin
            n_rel3++;
            r_cyc = int'(mc);
         end
      end
      if (n_rel2 != 1 || n_rel3 != 1 || r_cyc != 110) begin
         failures++;
         $display("FAIL bounce_release got rel2=%0d rel3=%0d cycle=%0d want 1 1 110",
                  n_rel2, n_rel3, r_cyc);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      int n_press = 0;
      int p_cyc   = -1;
      run_cycle('0, 1'b1);
      for (int k = 0; k < 25; k++) begin
         run_cycle(4'b0001, 1'b0);
         if (btn_press[0] === 1'b1) n_press++;
      end
      run_cycle(4'b0001, 1'b1);
      if (obs_vec !== '0) begin
         failures++;
         $display("FAIL reset_mid_outputs got=%b want=0", obs_vec);
      end
      checks++;
      for (int k = 0; k < 60; k++) begin
         run_cycle(4'b0001, 1'b0);
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL reset_mid mc=%0d got=%b want=%b", mc, obs_vec, exp_vec);
         end
         checks++;
         if (btn_press[0] === 1'b1) begin
            n_press++;
            p_cyc = int'(mc);
         end
      end
      if (n_press != 1 || p_cyc != 30) begin
         failures++;
         $display("FAIL reset_mid_press got count=%0d cycle=%0d want 1 at 30", n_press, p_cyc);
      end
      checks++;
   endtask

   task automatic test_simultaneous();
      run_cycle('0, 1'b1);
      for (int k = 0; k < 80; k++) begin
         run_cycle((k < 40) ? 4'b1111 : 4'b0000, 1'b0);
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL simultaneous mc=%0d got=%b want=%b", mc, obs_vec, exp_vec);
         end
         checks++;
         if (mc == 30 || mc == 70) begin
            if (btn_press !== ((mc == 30) ? 4'b1111 : 4'b0000) ||
                btn_release !== ((mc == 70) ? 4'b1111 : 4'b0000)) begin
               failures++;
               $display("FAIL simultaneous_pulse mc=%0d got press=%b rel=%b", mc, btn_press, btn_release);
            end
            checks++;
         end
      end
   endtask

   task automatic test_long_hold();
      int n_press = 0;
      int n_t15   = 0;
      int guard   = 0;
      int want;
`ifdef AUTOREPEAT_EN
      want = 8;
`else
      want = 1;
`endif
      run_cycle('0, 1'b1);
      while (n_t15 < 20 && guard < 2000) begin
         run_cycle(4'b0001, 1'b0);
         guard++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL long_hold mc=%0d got=%b want=%b", mc, obs_vec, exp_vec);
         end
         checks++;
         if (btn_press[0] === 1'b1) n_press++;
         if (tick_15 === 1'b1 && n_press > 0) n_t15++;
      end
      if (guard >= 2000) begin
         failures++;
         $display("FAIL long_hold_timeout got t15=%0d want 20", n_t15);
      end
      checks++;
      for (int k = 0; k < 2; k++) begin
         run_cycle(4'b0001, 1'b0);
         if (btn_press[0] === 1'b1) n_press++;
      end
      if (n_press != want) begin
         failures++;
         $display("FAIL long_hold_presses got=%0d want=%0d", n_press, want);
      end
      checks++;
   endtask

   task automatic test_random();
      int unsigned      hold_left [N_BTN];
      logic [N_BTN-1:0] b;
      logic             rst;
      b = '0;
      for (int i = 0; i < int'(N_BTN); i++) hold_left[i] = 0;
      run_cycle('0, 1'b1);
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < int'(N_BTN); i++) begin
            if (hold_left[i] == 0) begin
               b[i] = 1'($urandom_range(0, 1));
               hold_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25)
                                                           : $urandom_range(30, 90);
            end else begin
               hold_left[i]--;
            end
         end
         rst = ($urandom_range(0, 799) == 0);
         run_cycle(b, rst);
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL random mc=%0d got=%b want=%b", mc, obs_vec, exp_vec);
         end
         checks++;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      btn_in   = '0;
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_tick_gen();
      test_single_press();
      test_glitch();
      test_bounce_release();
      test_reset_mid();
      test_simultaneous();
      test_long_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
